// File: rtl/neuron_mac_ctrl.sv
// Dot-product sequencer for one neuron. It fetches operand pairs, drives a
// multi-cycle external multiplier, and accumulates the products into a
// 16-bit saturating accumulator.
module neuron_mac_ctrl #(
  parameter int MULT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  vec_len,
  input  logic        in_valid,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        in_ready,
  output logic [15:0] alu_op1,
  output logic [15:0] alu_op2,
  output logic [1:0]  alu_op_select,
  output logic        alu_enable,
  input  logic [15:0] alu_result,
  output logic [15:0] acc_out,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int CW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MULT_CYCLES - 1);
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [2:0] {IDLE, FETCH, MULT, ACC, DONE} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [4:0]     remaining_q;
  logic [15:0]    prod_q;
  logic [15:0]    acc_q;
  logic [15:0]    op1_q, op2_q;
  logic [1:0]     sel_q;
  logic           en_q, rdy_q, busy_q, done_q, ovf_q;

  // 17-bit sum with saturation: bits 16 and 15 disagree only on overflow
  logic [16:0] sum;
  logic [15:0] sat_sum;
  logic        sat_hit;
  assign sum = {acc_q[15], acc_q} + {prod_q[15], prod_q};

  // Clamp the sum to the signed 16-bit range and flag any clamp
  always_comb begin
    sat_sum = sum[15:0];
    sat_hit = 1'b0;
    if (sum[16] != sum[15]) begin
      sat_hit = 1'b1;
      sat_sum = sum[16] ? 16'h8000 : 16'h7FFF;
    end
  end

  // Control FSM; every output is a register updated on the state transition
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      remaining_q <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      sel_q       <= 2'b00;
      en_q        <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            remaining_q <= (vec_len == 4'd0) ? 5'd16 : {1'b0, vec_len};
            busy_q      <= 1'b1;
            rdy_q       <= 1'b1;
            state_q     <= FETCH;
          end
        end
        FETCH: begin
          if (in_valid) begin
            op1_q   <= in_a;
            op2_q   <= in_b;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            en_q    <= 1'b1;
            sel_q   <= OP_MUL;
            state_q <= MULT;
          end
        end
        MULT: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            prod_q  <= alu_result;
            en_q    <= 1'b0;
            sel_q   <= 2'b00;
            state_q <= ACC;
          end
        end
        ACC: begin
          acc_q       <= sat_sum;
          if (sat_hit) ovf_q <= 1'b1;
          remaining_q <= remaining_q - 5'd1;
          if (remaining_q == 5'd1) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            rdy_q   <= 1'b1;
            state_q <= FETCH;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready      = rdy_q;
  assign alu_op1       = op1_q;
  assign alu_op2       = op2_q;
  assign alu_op_select = sel_q;
  assign alu_enable    = en_q;
  assign acc_out       = acc_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// Directed bench for neuron_mac_ctrl: table of whole jobs plus hand-written
// sequences for cycle timing, stalls, ignored start and reset mid-multiply.
module tb_neuron_mac_ctrl;
  localparam int MC = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  vec_len = 4'd0;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0, in_b = '0;
  logic        in_ready;
  logic [15:0] alu_op1, alu_op2;
  logic [1:0]  alu_op_select;
  logic        alu_enable;
  logic [15:0] alu_result;
  logic [15:0] acc_out;
  logic        busy, done, overflow;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  neuron_mac_ctrl #(.MULT_CYCLES(MC)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .vec_len(vec_len),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op_select(alu_op_select),
    .alu_enable(alu_enable), .alu_result(alu_result), .acc_out(acc_out),
    .busy(busy), .done(done), .overflow(overflow)
  );

  // Multiplier model: the product is only valid on the last enabled cycle
  int mul_cnt = 0;
  logic signed [31:0] prod32;
  always @(posedge clock) mul_cnt <= alu_enable ? mul_cnt + 1 : 0;
  assign prod32 = $signed(alu_op1) * $signed(alu_op2);
  assign alu_result = (alu_enable && alu_op_select == 2'b10 && mul_cnt == MC - 1)
                      ? prod32[15:0] : 16'hDEAD;

  // Event monitor: handshakes, done pulses, in_ready seen during multiply
  int hs_cnt = 0, done_cnt = 0, rdy_mult = 0;
  always @(posedge clock) begin
    if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (alu_enable && in_ready) rdy_mult <= rdy_mult + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  typedef struct packed {
    logic [3:0]        vl;
    logic [4:0]        n;
    logic [15:0][15:0] a;
    logic [15:0][15:0] b;
    logic [15:0]       acc;
    logic              ovf;
  } vec_t;

  vec_t tbl [7];

  // Runs one job from a table entry and checks its result and bookkeeping
  task automatic run_job(input vec_t v, input string name);
    int t, hs0, d0, r0;
    hs0 = hs_cnt; d0 = done_cnt; r0 = rdy_mult;
    @(negedge clock);
    start = 1'b1; vec_len = v.vl;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < int'(v.n); i++) begin
      t = 0;
      while (!in_ready && t < 100) begin @(negedge clock); t++; end
      if (t >= 100) begin timeout({name, " in_ready"}); return; end
      in_valid = 1'b1; in_a = v.a[i]; in_b = v.b[i];
      @(negedge clock);
      in_valid = 1'b0;
    end
    t = 0;
    while (!done && t < 100) begin @(negedge clock); t++; end
    if (t >= 100) begin timeout({name, " done"}); return; end
    chk({name, " acc_out"}, acc_out, v.acc);
    chk({name, " overflow"}, overflow, v.ovf);
    @(negedge clock);
    chk({name, " busy_after"}, busy, 1'b0);
    chk({name, " done_pulses"}, done_cnt - d0, 1);
    chk({name, " handshakes"}, hs_cnt - hs0, v.n);
    chk({name, " rdy_in_mult"}, rdy_mult - r0, 0);
    chk({name, " acc_hold"}, acc_out, v.acc);
  endtask

  initial begin
    int en_cnt, done_at, bad, d0;

    tbl = '{default: '0};
    tbl[0].vl = 4'd1; tbl[0].n = 5'd1;
    tbl[0].a[0] = 16'd3; tbl[0].b[0] = 16'd4; tbl[0].acc = 16'd12;
    tbl[1].vl = 4'd3; tbl[1].n = 5'd3;
    tbl[1].a[0] = 16'd2;  tbl[1].b[0] = 16'd5;
    tbl[1].a[1] = -16'sd3; tbl[1].b[1] = 16'd4;
    tbl[1].a[2] = 16'd7;  tbl[1].b[2] = 16'd1; tbl[1].acc = 16'd5;
    tbl[2].vl = 4'd2; tbl[2].n = 5'd2;
    tbl[2].a[0] = 16'd200; tbl[2].b[0] = 16'd100;
    tbl[2].a[1] = 16'd200; tbl[2].b[1] = 16'd100;
    tbl[2].acc = 16'h7FFF; tbl[2].ovf = 1'b1;
    tbl[3].vl = 4'd2; tbl[3].n = 5'd2;
    tbl[3].a[0] = -16'sd200; tbl[3].b[0] = 16'd100;
    tbl[3].a[1] = -16'sd200; tbl[3].b[1] = 16'd100;
    tbl[3].acc = 16'h8000; tbl[3].ovf = 1'b1;
    tbl[4].vl = 4'd0; tbl[4].n = 5'd16;
    for (int i = 0; i < 16; i++) begin tbl[4].a[i] = 16'd1; tbl[4].b[i] = 16'd1; end
    tbl[4].acc = 16'd16;
    tbl[5].vl = 4'd2; tbl[5].n = 5'd2;
    tbl[5].a[0] = -16'sd7; tbl[5].b[0] = 16'd9;
    tbl[5].a[1] = 16'd5;   tbl[5].b[1] = 16'd5; tbl[5].acc = -16'sd38;
    tbl[6].vl = 4'd1; tbl[6].n = 5'd1;
    tbl[6].a[0] = 16'd2; tbl[6].b[0] = 16'd3; tbl[6].acc = 16'd6;

    // Reset state
    #12;
    chk("rst acc_out", acc_out, 0);
    chk("rst flags", {busy, done, overflow, in_ready, alu_enable}, 0);
    chk("rst alu", {alu_op_select, alu_op1, alu_op2}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Exact cycle timing of a single pair (3,4)
    start = 1'b1; vec_len = 4'd1; in_valid = 1'b1; in_a = 16'd3; in_b = 16'd4;
    @(negedge clock);
    start = 1'b0;
    chk("t0 busy/in_ready/en", {busy, in_ready, alu_enable}, 3'b110);
    en_cnt = 0; done_at = -1; bad = 0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clock);
      in_valid = 1'b0;
      if (alu_enable) begin
        en_cnt++;
        if (k < 1 || k > 16) bad++;
        if (alu_op_select != 2'b10 || alu_op1 != 16'd3 || alu_op2 != 16'd4 || in_ready) bad++;
      end else if (alu_op_select != 2'b00) bad++;
      if (done) done_at = k;
    end
    chk("t enable cycles", en_cnt, 16);
    chk("t enable window", bad, 0);
    chk("t done cycle", done_at, 18);
    chk("t acc_out", acc_out, 12);
    chk("t busy end", busy, 1'b0);
    chk("t ops hold", {alu_op1, alu_op2}, {16'd3, 16'd4});

    // Table of whole jobs
    for (int i = 0; i < 6; i++) run_job(tbl[i], $sformatf("vec%0d", i));

    // Stall in FETCH, then a start pulse during MULT must be ignored
    d0 = done_cnt;
    @(negedge clock);
    start = 1'b1; vec_len = 4'd1;
    @(negedge clock);
    start = 1'b0; bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (!in_ready || alu_enable || !busy) bad++;
      @(negedge clock);
    end
    chk("stall held", bad, 0);
    in_valid = 1'b1; in_a = 16'd6; in_b = 16'd7;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("stall in mult", alu_enable, 1'b1);
    start = 1'b1; vec_len = 4'd5;
    @(negedge clock);
    start = 1'b0;
    begin
      int t = 0;
      while (!done && t < 100) begin @(negedge clock); t++; end
      if (t >= 100) timeout("ignore done");
    end
    chk("ignore acc_out", acc_out, 42);
    repeat (25) @(negedge clock);
    chk("ignore one done", done_cnt - d0, 1);
    chk("ignore idle", {busy, in_ready}, 2'b00);

    // Reset at MULT cycle 8
    d0 = done_cnt;
    start = 1'b1; vec_len = 4'd1;
    @(negedge clock);
    start = 1'b0; in_valid = 1'b1; in_a = 16'd9; in_b = 16'd9;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (7) @(negedge clock);
    chk("pre-reset in mult", alu_enable, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid rst flags", {busy, done, overflow, in_ready, alu_enable}, 0);
    chk("mid rst data", {acc_out, alu_op1, alu_op2, 14'd0, alu_op_select}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (25) @(negedge clock);
    chk("mid rst no done", done_cnt - d0, 0);
    chk("mid rst idle", busy, 1'b0);
    run_job(tbl[6], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound on total run time
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
